// File: rtl/controlador_vai_vem_pkg.sv
// Shared types and helpers for the vai/vem step sequencer.
package controlador_vai_vem_pkg;

    typedef enum logic [1:0] {
        PARADO    = 2'd0,
        ESPERA    = 2'd1,
        PASSO     = 2'd2,
        CONCLUIDO = 2'd3
    } estado_t;

    typedef enum logic {
        SOBE  = 1'b0,
        DESCE = 1'b1
    } dir_t;

    // Clamp a position request to the last valid position m-1.
    function automatic int unsigned sat(input int unsigned x, input int unsigned m);
        return (x > m - 1) ? m - 1 : x;
    endfunction

endpackage

// File: rtl/controlador_vai_vem_contador_tick.sv
// Step-rate tick counter: counts 0..T-1 while enabled; o_wrap is high while the count sits at T-1.
module controlador_vai_vem_contador_tick #(
    parameter int unsigned T = 50
) (
    input  logic clock,
    input  logic zera_s,
    input  logic i_clr,
    input  logic i_en,
    output logic o_wrap
);

    localparam int unsigned TW   = (T > 2) ? $clog2(T) : 1;
    localparam logic [TW-1:0] TPRE = TW'(T - 2);

    logic [TW-1:0] r_cnt;
    logic          r_wrap;

    // Count with clear priority; the wrap flag is registered one count ahead so it aligns with T-1.
    always_ff @(posedge clock) begin
        if (zera_s || i_clr) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else if (i_en) begin
            if (r_wrap) begin
                r_cnt  <= '0;
                r_wrap <= 1'b0;
            end else begin
                r_cnt  <= r_cnt + TW'(1);
                r_wrap <= (r_cnt == TPRE);
            end
        end
    end

    assign o_wrap = r_wrap;

endmodule

// File: rtl/controlador_vai_vem.sv
// Command-side driver for the saturating up/down position counter, with a local position mirror.
module controlador_vai_vem
    import controlador_vai_vem_pkg::*;
#(
    parameter int unsigned M = 100,
    parameter int unsigned N = 7,
    parameter int unsigned T = 50
) (
    input  logic         clock,
    input  logic         zera_s,
    input  logic         inicia,
    input  logic         modo,
    input  logic [N-1:0] alvo,
    input  logic         para,
    input  logic         pausa,
    input  logic         carrega,
    input  logic [N-1:0] pos_carga,
    output logic         vai,
    output logic         vem,
    output logic         set_pos,
    output logic [N-1:0] D,
    output logic [N-1:0] pos,
    output logic         ocupado,
    output logic         pronto,
    output logic         fim,
    output logic         meio
);

    localparam logic [N-1:0] POS_MAX  = N'(M - 1);
    localparam logic [N-1:0] POS_MEIO = N'(M / 2 - 1);

    estado_t      r_estado;
    logic         r_modo;
    logic [N-1:0] r_alvo;
    dir_t         r_dir;
    logic [N-1:0] r_pos;
    logic         r_ocupado;
    logic         r_pronto;

    estado_t      w_prox;
    logic         w_vai;
    logic         w_vem;
    logic         w_set_pos;
    logic [N-1:0] w_d;
    logic [N-1:0] w_pos_prox;
    dir_t         w_dir_prox;
    logic [N-1:0] w_alvo_prox;
    logic         w_modo_prox;
    logic         w_tick_clr;
    logic         w_tick_en;
    logic         w_wrap;
    logic         w_sobe;
    logic [N-1:0] w_pos_passo;
    logic [N-1:0] w_alvo_sat;
    logic [N-1:0] w_carga_sat;

    assign w_alvo_sat  = N'(sat(32'(alvo), M));
    assign w_carga_sat = N'(sat(32'(pos_carga), M));

    // Step direction; in sweep mode the direction flips before stepping at either end of the range.
    always_comb begin
        w_sobe = 1'b0;
        if (!r_modo) begin
            w_sobe = (r_alvo > r_pos);
        end else if (r_dir == SOBE) begin
            w_sobe = (r_pos != POS_MAX);
        end else begin
            w_sobe = (r_pos == '0);
        end
    end

    assign w_pos_passo = w_sobe ? (r_pos + N'(1)) : (r_pos - N'(1));

    controlador_vai_vem_contador_tick #(
        .T (T)
    ) u_tick (
        .clock  (clock),
        .zera_s (zera_s),
        .i_clr  (w_tick_clr),
        .i_en   (w_tick_en),
        .o_wrap (w_wrap)
    );

    // Next-state, pulse and mirror-update logic; para suppresses the PASSO pulse in the same cycle.
    always_comb begin
        w_prox      = r_estado;
        w_vai       = 1'b0;
        w_vem       = 1'b0;
        w_set_pos   = 1'b0;
        w_d         = '0;
        w_pos_prox  = r_pos;
        w_dir_prox  = r_dir;
        w_alvo_prox = r_alvo;
        w_modo_prox = r_modo;
        w_tick_clr  = 1'b0;
        w_tick_en   = 1'b0;

        case (r_estado)
            PARADO: begin
                w_tick_clr = 1'b1;
                if (para) begin
                    w_prox = PARADO;
                end else if (carrega) begin
                    w_set_pos  = 1'b1;
                    w_d        = w_carga_sat;
                    w_pos_prox = w_carga_sat;
                end else if (inicia) begin
                    w_modo_prox = modo;
                    if (!modo) begin
                        w_alvo_prox = w_alvo_sat;
                        w_prox      = (w_alvo_sat == r_pos) ? CONCLUIDO : ESPERA;
                    end else begin
                        w_prox = ESPERA;
                    end
                end
            end
            ESPERA: begin
                if (para) begin
                    w_prox = PARADO;
                end else begin
                    w_tick_en = !pausa;
                    if (w_wrap && !pausa) begin
                        w_prox = PASSO;
                    end
                end
            end
            PASSO: begin
                w_tick_clr = 1'b1;
                if (para) begin
                    w_prox = PARADO;
                end else begin
                    w_vai      = w_sobe;
                    w_vem      = !w_sobe;
                    w_pos_prox = w_pos_passo;
                    if (!r_modo) begin
                        w_prox = (w_pos_passo == r_alvo) ? CONCLUIDO : ESPERA;
                    end else begin
                        w_prox = ESPERA;
                        if (w_pos_passo == POS_MAX) begin
                            w_dir_prox = DESCE;
                        end else if (w_pos_passo == '0) begin
                            w_dir_prox = SOBE;
                        end else begin
                            w_dir_prox = w_sobe ? SOBE : DESCE;
                        end
                    end
                end
            end
            CONCLUIDO: begin
                w_prox = PARADO;
            end
            default: begin
                w_prox = PARADO;
            end
        endcase

        if (zera_s) begin
            w_vai     = 1'b0;
            w_vem     = 1'b0;
            w_set_pos = 1'b0;
            w_d       = '0;
        end
    end

    // State, mirror and registered status outputs.
    always_ff @(posedge clock) begin
        if (zera_s) begin
            r_estado  <= PARADO;
            r_modo    <= 1'b0;
            r_alvo    <= '0;
            r_dir     <= SOBE;
            r_pos     <= '0;
            r_ocupado <= 1'b0;
            r_pronto  <= 1'b0;
        end else begin
            r_estado  <= w_prox;
            r_modo    <= w_modo_prox;
            r_alvo    <= w_alvo_prox;
            r_dir     <= w_dir_prox;
            r_pos     <= w_pos_prox;
            r_ocupado <= (w_prox == ESPERA) || (w_prox == PASSO);
            r_pronto  <= (w_prox == CONCLUIDO);
        end
    end

    assign vai     = w_vai;
    assign vem     = w_vem;
    assign set_pos = w_set_pos;
    assign D       = w_d;
    assign pos     = r_pos;
    assign ocupado = r_ocupado;
    assign pronto  = r_pronto;
    assign fim     = (r_pos == POS_MAX);
    assign meio    = (r_pos == POS_MEIO);

endmodule

// File: tb/tb_controlador_vai_vem.sv
// Scoreboard bench: stimulus pushes expected pulse events, negedge monitors pop and compare.
module tb_controlador_vai_vem;

    localparam int unsigned M  = 100;
    localparam int unsigned N  = 7;
    localparam int unsigned T  = 4;
    localparam int unsigned M5 = 5;
    localparam int unsigned N5 = 3;
    localparam int unsigned T5 = 2;

    localparam int EV_VAI = 0;
    localparam int EV_VEM = 1;
    localparam int EV_SET = 2;
    localparam int EV_PRO = 3;

    typedef struct {
        int kind;
        int cyc;
        int val;
    } ev_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          zera_s, inicia, modo, para, pausa, carrega;
    logic [N-1:0]  alvo, pos_carga;
    logic          vai, vem, set_pos, ocupado, pronto, fim, meio;
    logic [N-1:0]  d, pos;

    logic          zera_s_5, inicia_5, modo_5, para_5, pausa_5, carrega_5;
    logic [N5-1:0] alvo_5, pos_carga_5;
    logic          vai_5, vem_5, set_pos_5, ocupado_5, pronto_5, fim_5, meio_5;
    logic [N5-1:0] d_5, pos_5;

    controlador_vai_vem #(.M(M), .N(N), .T(T)) dut (
        .clock(clock), .zera_s(zera_s), .inicia(inicia), .modo(modo), .alvo(alvo),
        .para(para), .pausa(pausa), .carrega(carrega), .pos_carga(pos_carga),
        .vai(vai), .vem(vem), .set_pos(set_pos), .D(d), .pos(pos),
        .ocupado(ocupado), .pronto(pronto), .fim(fim), .meio(meio)
    );

    controlador_vai_vem #(.M(M5), .N(N5), .T(T5)) dut5 (
        .clock(clock), .zera_s(zera_s_5), .inicia(inicia_5), .modo(modo_5), .alvo(alvo_5),
        .para(para_5), .pausa(pausa_5), .carrega(carrega_5), .pos_carga(pos_carga_5),
        .vai(vai_5), .vem(vem_5), .set_pos(set_pos_5), .D(d_5), .pos(pos_5),
        .ocupado(ocupado_5), .pronto(pronto_5), .fim(fim_5), .meio(meio_5)
    );

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    ev_t  q[$];
    ev_t  q5[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int which, input int kind, input int c, input int val);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.val  = val;
        if (which == 0) q.push_back(e);
        else            q5.push_back(e);
    endtask

    task automatic observe(input int which, input int kind, input int val, input bit m_meio, input bit m_fim);
        ev_t e;
        bit  empty;
        tests++;
        empty = (which == 0) ? (q.size() == 0) : (q5.size() == 0);
        if (empty) begin
            fails++;
            $display("FAIL sb%0d_unexpected: got kind %0d val %0d at cycle %0d, required no event",
                     which, kind, val, cyc);
        end else begin
            if (which == 0) e = q.pop_front();
            else            e = q5.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.val != val) begin
                fails++;
                $display("FAIL sb%0d_event: got kind %0d cycle %0d val %0d, required kind %0d cycle %0d val %0d",
                         which, kind, cyc, val, e.kind, e.cyc, e.val);
            end
            if (which == 1) begin
                check("sweep_meio", int'(m_meio), int'(e.val == 1));
                check("sweep_fim", int'(m_fim), int'(e.val == int'(M5) - 1));
            end
        end
    endtask

    // Monitors: every presented pulse consumes one expected event.
    always @(negedge clock) begin
        if (vai)     observe(0, EV_VAI, int'(pos), meio, fim);
        if (vem)     observe(0, EV_VEM, int'(pos), meio, fim);
        if (set_pos) observe(0, EV_SET, int'(d), meio, fim);
        if (pronto)  observe(0, EV_PRO, int'(pos), meio, fim);
    end

    always @(negedge clock) begin
        if (vai_5)     observe(1, EV_VAI, int'(pos_5), meio_5, fim_5);
        if (vem_5)     observe(1, EV_VEM, int'(pos_5), meio_5, fim_5);
        if (set_pos_5) observe(1, EV_SET, int'(d_5), meio_5, fim_5);
        if (pronto_5)  observe(1, EV_PRO, int'(pos_5), meio_5, fim_5);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) step();
    endtask

    initial begin
        int p;
        int k5[10];
        int v5[10];
        k5 = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
        v5 = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 1};

        zera_s = 1'b1; inicia = 1'b0; modo = 1'b0; alvo = '0;
        para = 1'b0; pausa = 1'b0; carrega = 1'b0; pos_carga = '0;
        zera_s_5 = 1'b1; inicia_5 = 1'b0; modo_5 = 1'b0; alvo_5 = '0;
        para_5 = 1'b0; pausa_5 = 1'b0; carrega_5 = 1'b0; pos_carga_5 = '0;
        step(); step(); step();
        check("rst_pos", int'(pos), 0);
        check("rst_ocupado", int'(ocupado), 0);
        check("rst_pronto", int'(pronto), 0);
        check("rst_pulses", int'({vai, vem, set_pos}), 0);
        check("rst_d", int'(d), 0);
        check("rst_fim_meio", int'({fim, meio}), 0);
        check("rst_pos5", int'(pos_5), 0);
        zera_s = 1'b0; zera_s_5 = 1'b0;
        step();

        // Move 0 -> 3; alvo changed after acceptance must be ignored.
        modo = 1'b0; alvo = 7'd3; inicia = 1'b1; p = cyc + 1;
        push(0, EV_VAI, p + T, 0);
        push(0, EV_VAI, p + T + (T + 1), 1);
        push(0, EV_VAI, p + T + 2 * (T + 1), 2);
        push(0, EV_PRO, p + 3 * (T + 1), 3);
        step(); inicia = 1'b0; alvo = 7'd50;
        check("ocupado_espera", int'(ocupado), 1);
        wait_to(p + 3 * (T + 1) + 1);
        check("move_up_pos", int'(pos), 3);
        check("move_up_idle", int'(ocupado), 0);

        // Reset mid-motion after the second pulse.
        alvo = 7'd6; inicia = 1'b1; p = cyc + 1;
        push(0, EV_VAI, p + T, 3);
        push(0, EV_VAI, p + T + (T + 1), 4);
        step(); inicia = 1'b0;
        wait_to(p + 2 * (T + 1));
        check("pre_reset_pos", int'(pos), 5);
        zera_s = 1'b1;
        step();
        check("mid_rst_pos", int'(pos), 0);
        check("mid_rst_status", int'({ocupado, pronto, vai, vem, set_pos}), 0);
        zera_s = 1'b0;
        step();

        // Load 10, move down to 8, then a zero-step move.
        carrega = 1'b1; pos_carga = 7'd10; push(0, EV_SET, cyc, 10);
        step(); carrega = 1'b0;
        check("load_pos", int'(pos), 10);
        alvo = 7'd8; inicia = 1'b1; p = cyc + 1;
        push(0, EV_VEM, p + T, 10);
        push(0, EV_VEM, p + T + (T + 1), 9);
        push(0, EV_PRO, p + 2 * (T + 1), 8);
        step(); inicia = 1'b0;
        wait_to(p + 2 * (T + 1) + 1);
        check("move_down_pos", int'(pos), 8);
        inicia = 1'b1; p = cyc + 1;
        push(0, EV_PRO, p, 8);
        step(); inicia = 1'b0;
        check("zero_move_not_busy", int'(ocupado), 0);
        step(); step();

        // Saturation of load value and target; no vai beyond M-1.
        carrega = 1'b1; pos_carga = 7'd127; push(0, EV_SET, cyc, 99);
        step(); carrega = 1'b0;
        check("sat_load_pos", int'(pos), 99);
        check("sat_load_fim", int'(fim), 1);
        carrega = 1'b1; pos_carga = 7'd97; push(0, EV_SET, cyc, 97);
        step(); carrega = 1'b0;
        check("load97_fim", int'(fim), 0);
        alvo = 7'd120; inicia = 1'b1; p = cyc + 1;
        push(0, EV_VAI, p + T, 97);
        push(0, EV_VAI, p + T + (T + 1), 98);
        push(0, EV_PRO, p + 2 * (T + 1), 99);
        step(); inicia = 1'b0;
        wait_to(p + 2 * (T + 1) + 1);
        check("sat_move_pos", int'(pos), 99);
        check("sat_move_fim", int'(fim), 1);
        inicia = 1'b1; p = cyc + 1;
        push(0, EV_PRO, p, 99);
        step(); inicia = 1'b0;
        wait_to(cyc + 2 * (T + 1));
        check("sat_hold_pos", int'(pos), 99);

        // Sweep on the M=5 instance, stopped with para during ESPERA.
        modo_5 = 1'b1; inicia_5 = 1'b1; p = cyc + 1;
        for (int i = 0; i < 10; i++) push(1, k5[i], p + int'(T5) + i * int'(T5 + 1), v5[i]);
        step(); inicia_5 = 1'b0;
        wait_to(p + int'(T5) + 9 * int'(T5 + 1) + 1);
        para_5 = 1'b1;
        step(); para_5 = 1'b0;
        check("sweep_stop_idle", int'(ocupado_5), 0);
        check("sweep_stop_pos", int'(pos_5), 2);

        // Abort in the PASSO cycle; para with inicia in PARADO.
        carrega = 1'b1; pos_carga = 7'd20; push(0, EV_SET, cyc, 20);
        step(); carrega = 1'b0;
        alvo = 7'd22; inicia = 1'b1; p = cyc + 1;
        push(0, EV_VAI, p + T, 20);
        step(); inicia = 1'b0;
        wait_to(p + T + (T + 1));
        para = 1'b1;
        step(); para = 1'b0;
        check("abort_pos", int'(pos), 21);
        check("abort_idle", int'({ocupado, pronto}), 0);
        para = 1'b1; inicia = 1'b1; alvo = 7'd30;
        step(); para = 1'b0; inicia = 1'b0;
        check("para_inicia_idle", int'(ocupado), 0);
        wait_to(cyc + 2 * (T + 1));
        check("para_inicia_pos", int'(pos), 21);

        // Pause for 10 cycles in ESPERA; carrega while busy is ignored.
        alvo = 7'd23; inicia = 1'b1; p = cyc + 1;
        push(0, EV_VAI, p + T, 21);
        push(0, EV_VAI, p + T + (T + 1) + 10, 22);
        push(0, EV_PRO, p + 2 * (T + 1) + 10, 23);
        step(); inicia = 1'b0;
        wait_to(p + 6);
        pausa = 1'b1;
        wait_to(p + 12);
        carrega = 1'b1; pos_carga = 7'd5;
        step(); carrega = 1'b0;
        check("busy_load_pos", int'(pos), 22);
        wait_to(p + 16);
        pausa = 1'b0;
        wait_to(p + 2 * (T + 1) + 11);
        check("pause_final_pos", int'(pos), 23);

        step(); step();
        check("sb_drained", q.size(), 0);
        check("sb5_drained", q5.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
